// File: rtl/vga_board_arbiter_if.sv
// Board-access bus between the game engine / VGA pipeline and the tile board arbiter.
// The master side drives timing, read address and requests; the slave side is the arbiter.
interface vga_board_arbiter_if;
    logic [9:0] hc;
    logic [9:0] vc;
    logic [3:0] rd_addr;
    logic [3:0] rd_data;
    logic       wr_req;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_ack;
    logic       clr_req;
    logic       clr_ack;
    logic       busy;
    logic       frame_start;

    modport master (
        output hc, vc, rd_addr, wr_req, wr_addr, wr_data, clr_req,
        input  rd_data, wr_ack, clr_ack, busy, frame_start
    );

    modport slave (
        input  hc, vc, rd_addr, wr_req, wr_addr, wr_data, clr_req,
        output rd_data, wr_ack, clr_ack, busy, frame_start
    );
endinterface

// File: rtl/vga_board_arbiter.sv
// 4x4 tile board shared by the game FSM and the VGA renderer.
// Reads are served every cycle; writes and clears only land during vertical blanking.
module vga_board_arbiter #(
    parameter logic [9:0] VBP = 10'd31,
    parameter logic [9:0] VFP = 10'd511
) (
    input logic dclk,
    input logic rst_n,
    vga_board_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        WACK,
        CACK
    } state_t;

    state_t     state;
    logic [3:0] idx;
    logic [3:0] mem [16];
    logic [3:0] rd_data_q;
    logic       wr_ack_q;
    logic       clr_ack_q;
    logic       busy_q;
    logic       frame_start_q;
    logic       vblank;

    assign vblank = (bus.vc >= VFP) || (bus.vc < VBP);

    // Board ownership FSM; an interrupted clear simply parks idx until blanking returns.
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 4'd0;
            wr_ack_q  <= 1'b0;
            clr_ack_q <= 1'b0;
            busy_q    <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                mem[i] <= 4'd0;
            end
        end else begin
            wr_ack_q  <= 1'b0;
            clr_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (vblank && bus.clr_req) begin
                        state  <= CLEAR;
                        idx    <= 4'd0;
                        busy_q <= 1'b1;
                    end else if (vblank && bus.wr_req) begin
                        mem[bus.wr_addr] <= bus.wr_data;
                        state            <= WACK;
                        wr_ack_q         <= 1'b1;
                        busy_q           <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (vblank) begin
                        mem[idx] <= 4'd0;
                        if (idx == 4'd15) begin
                            state     <= CACK;
                            clr_ack_q <= 1'b1;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                WACK: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                CACK: begin
                    state  <= IDLE;
                    idx    <= 4'd0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Display port sees the pre-edge contents, so a same-cycle write shows up one cycle later.
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q     <= 4'd0;
            frame_start_q <= 1'b0;
        end else begin
            rd_data_q     <= mem[bus.rd_addr];
            frame_start_q <= (bus.vc == VFP) && (bus.hc == 10'd0);
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.wr_ack      = wr_ack_q;
    assign bus.clr_ack     = clr_ack_q;
    assign bus.busy        = busy_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_board_arbiter.sv
// Self-checking bench for vga_board_arbiter: the bench acts as the timing generator
// and game engine, and a read scoreboard checks every display read against a board model.
module tb_vga_board_arbiter;

    typedef struct {
        logic [3:0] addr;
        logic [3:0] data;
    } rd_exp_t;

    logic dclk;
    logic rst_n;
    logic rd_vld;
    logic rd_vld_d;
    logic [3:0] model [16];
    rd_exp_t exp_q [$];
    int checks;
    int errors;

    vga_board_arbiter_if bus ();

    vga_board_arbiter dut (
        .dclk  (dclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        dclk = 1'b0;
        forever #20 dclk = ~dclk;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Read scoreboard: one pending expectation per read address presented.
    always @(posedge dclk) rd_vld_d <= rd_vld;

    always @(negedge dclk) begin
        if (rd_vld_d) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL rd_scoreboard_empty got %h exp none", bus.rd_data);
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                if (bus.rd_data !== e.data) begin
                    errors++;
                    $display("[TB] FAIL rd_data addr %0d got %h exp %h", e.addr, bus.rd_data, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge dclk);
        #1;
        if (bus.hc == 10'd799) begin
            bus.hc = 10'd0;
            bus.vc = (bus.vc == 10'd520) ? 10'd0 : bus.vc + 10'd1;
        end else begin
            bus.hc = bus.hc + 10'd1;
        end
    endtask

    task automatic set_pos(input int v, input int h);
        bus.vc = 10'(v);
        bus.hc = 10'(h);
    endtask

    task automatic read_addr(input int a);
        rd_exp_t e;
        bus.rd_addr = 4'(a);
        e.addr = 4'(a);
        e.data = model[a];
        exp_q.push_back(e);
        rd_vld = 1'b1;
        tick();
        rd_vld = 1'b0;
    endtask

    task automatic read_all();
        for (int a = 0; a < 16; a++) begin
            read_addr(a);
        end
    endtask

    task automatic do_write(input int a, input logic [3:0] d);
        bit seen;
        seen = 0;
        set_pos(5, 0);
        bus.wr_addr = 4'(a);
        bus.wr_data = d;
        bus.wr_req  = 1'b1;
        for (int n = 0; n < 10 && !seen; n++) begin
            tick();
            if (bus.wr_ack === 1'b1) seen = 1;
        end
        bus.wr_req = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL preload_wr_ack got 0 exp 1 addr %0d", a);
        end
        model[a] = d;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (bus.rd_data !== 4'd0) begin errors++; $display("[TB] FAIL reset_rd_data got %h exp 0", bus.rd_data); end
        checks++; if (bus.wr_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_ack got %b exp 0", bus.wr_ack); end
        checks++; if (bus.clr_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_clr_ack got %b exp 0", bus.clr_ack); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.frame_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_start got %b exp 0", bus.frame_start); end
        rst_n = 1'b1;
        tick();
        read_all();
        checks++;
        if ({bus.wr_ack, bus.clr_ack, bus.busy} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL post_reset_idle got %b exp 000", {bus.wr_ack, bus.clr_ack, bus.busy});
        end
    endtask

    task automatic test_deferred_write();
        set_pos(100, 0);
        bus.wr_addr = 4'd5;
        bus.wr_data = 4'hB;
        bus.wr_req  = 1'b1;
        for (int n = 0; n < 40; n++) begin
            tick();
            checks++;
            if (bus.wr_ack !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL active_write_held got ack %b busy %b exp 0 0", bus.wr_ack, bus.busy);
            end
        end
        set_pos(510, 790);
        for (int n = 0; n < 10; n++) begin
            tick();
            checks++;
            if (bus.wr_ack !== 1'b0 || bus.frame_start !== 1'b0) begin
                errors++;
                $display("[TB] FAIL pre_vfp_idle got ack %b fs %b exp 0 0", bus.wr_ack, bus.frame_start);
            end
        end
        tick();
        checks++; if (bus.frame_start !== 1'b1) begin errors++; $display("[TB] FAIL frame_start got %b exp 1", bus.frame_start); end
        checks++; if (bus.wr_ack !== 1'b1) begin errors++; $display("[TB] FAIL vfp_wr_ack got %b exp 1", bus.wr_ack); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL wack_busy got %b exp 1", bus.busy); end
        bus.wr_req = 1'b0;
        model[5] = 4'hB;
        tick();
        checks++;
        if ({bus.wr_ack, bus.frame_start, bus.busy} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL after_wack got %b exp 000", {bus.wr_ack, bus.frame_start, bus.busy});
        end
        read_addr(5);
    endtask

    task automatic test_boundary();
        set_pos(30, 799);
        bus.wr_addr = 4'd1;
        bus.wr_data = 4'h9;
        bus.wr_req  = 1'b1;
        tick();
        checks++; if (bus.wr_ack !== 1'b1) begin errors++; $display("[TB] FAIL vbp_minus1_accept got %b exp 1", bus.wr_ack); end
        bus.wr_req = 1'b0;
        model[1] = 4'h9;
        tick();
        set_pos(31, 0);
        bus.wr_addr = 4'd2;
        bus.wr_data = 4'h6;
        bus.wr_req  = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            checks++;
            if (bus.wr_ack !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL vbp_reject got ack %b busy %b exp 0 0", bus.wr_ack, bus.busy);
            end
        end
        set_pos(510, 799);
        tick();
        checks++; if (bus.wr_ack !== 1'b0) begin errors++; $display("[TB] FAIL vfp_minus1_reject got %b exp 0", bus.wr_ack); end
        tick();
        checks++; if (bus.wr_ack !== 1'b1) begin errors++; $display("[TB] FAIL vfp_accept got %b exp 1", bus.wr_ack); end
        bus.wr_req = 1'b0;
        model[2] = 4'h6;
        tick();
        read_addr(1);
        read_addr(2);
    endtask

    task automatic test_full_clear();
        for (int a = 0; a < 16; a++) do_write(a, 4'hF);
        read_all();
        set_pos(510, 790);
        bus.clr_req = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            checks++;
            if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL clr_wait_busy got %b exp 0", bus.busy); end
        end
        tick();
        for (int n = 1; n <= 16; n++) begin
            tick();
            checks++;
            if (bus.busy !== 1'b1 || bus.clr_ack !== (n == 16) || bus.wr_ack !== 1'b0) begin
                errors++;
                $display("[TB] FAIL clear_cycle %0d got busy %b ack %b exp 1 %b", n, bus.busy, bus.clr_ack, (n == 16));
            end
        end
        bus.clr_req = 1'b0;
        for (int a = 0; a < 16; a++) model[a] = 4'd0;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.clr_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_cack got busy %b ack %b exp 0 0", bus.busy, bus.clr_ack);
        end
        read_all();
    endtask

    task automatic test_interrupted_clear();
        for (int a = 0; a < 16; a++) do_write(a, 4'hF);
        set_pos(30, 788);
        bus.clr_req = 1'b1;
        tick();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL int_clr_accept got %b exp 1", bus.busy); end
        for (int n = 0; n < 11; n++) begin
            tick();
            checks++;
            if (bus.clr_ack !== 1'b0) begin errors++; $display("[TB] FAIL int_clr_early_ack got %b exp 0", bus.clr_ack); end
        end
        for (int a = 0; a <= 10; a++) model[a] = 4'd0;
        read_all();
        set_pos(300, 0);
        for (int n = 0; n < 5; n++) tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.clr_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL int_clr_parked got busy %b ack %b exp 1 0", bus.busy, bus.clr_ack);
        end
        set_pos(510, 795);
        for (int n = 0; n < 5; n++) tick();
        for (int n = 1; n <= 5; n++) begin
            tick();
            checks++;
            if (bus.clr_ack !== (n == 5) || bus.busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL resume_cycle %0d got ack %b busy %b exp %b 1", n, bus.clr_ack, bus.busy, (n == 5));
            end
        end
        bus.clr_req = 1'b0;
        for (int a = 0; a < 16; a++) model[a] = 4'd0;
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL resume_idle got %b exp 0", bus.busy); end
        read_all();
    endtask

    task automatic test_priority();
        do_write(0, 4'h7);
        do_write(3, 4'h7);
        do_write(9, 4'h7);
        set_pos(0, 100);
        bus.clr_req = 1'b1;
        bus.wr_req  = 1'b1;
        bus.wr_addr = 4'd3;
        bus.wr_data = 4'h2;
        tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.wr_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prio_clear_first got busy %b wr_ack %b exp 1 0", bus.busy, bus.wr_ack);
        end
        for (int n = 1; n <= 16; n++) begin
            tick();
            checks++;
            if (bus.wr_ack !== 1'b0 || bus.clr_ack !== (n == 16)) begin
                errors++;
                $display("[TB] FAIL prio_clear_cycle %0d got wr_ack %b clr_ack %b", n, bus.wr_ack, bus.clr_ack);
            end
        end
        bus.clr_req = 1'b0;
        tick();
        checks++;
        if ({bus.wr_ack, bus.clr_ack, bus.busy} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL prio_idle got %b exp 000", {bus.wr_ack, bus.clr_ack, bus.busy});
        end
        tick();
        checks++; if (bus.wr_ack !== 1'b1) begin errors++; $display("[TB] FAIL prio_write_ack got %b exp 1", bus.wr_ack); end
        bus.wr_req = 1'b0;
        tick();
        for (int a = 0; a < 16; a++) model[a] = 4'd0;
        model[3] = 4'h2;
        read_all();
    endtask

    task automatic test_read_during_write();
        rd_exp_t e;
        do_write(7, 4'h1);
        set_pos(10, 0);
        bus.rd_addr = 4'd7;
        bus.wr_addr = 4'd7;
        bus.wr_data = 4'h4;
        bus.wr_req  = 1'b1;
        e.addr = 4'd7;
        e.data = 4'h1;
        exp_q.push_back(e);
        rd_vld = 1'b1;
        tick();
        checks++; if (bus.wr_ack !== 1'b1) begin errors++; $display("[TB] FAIL rdw_wr_ack got %b exp 1", bus.wr_ack); end
        bus.wr_req = 1'b0;
        model[7] = 4'h4;
        e.data = 4'h4;
        exp_q.push_back(e);
        tick();
        rd_vld = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_clear();
        do_write(12, 4'hF);
        do_write(14, 4'hF);
        set_pos(5, 0);
        bus.clr_req = 1'b1;
        tick();
        for (int n = 0; n < 8; n++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.clr_ack, bus.wr_ack, bus.frame_start} !== 4'b0000 || bus.rd_data !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_clear got flags %b rd %h exp 0000 0",
                     {bus.busy, bus.clr_ack, bus.wr_ack, bus.frame_start}, bus.rd_data);
        end
        bus.clr_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) model[a] = 4'd0;
        for (int n = 0; n < 20; n++) begin
            tick();
            checks++;
            if (bus.clr_ack !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL aborted_clear_ack got ack %b busy %b exp 0 0", bus.clr_ack, bus.busy);
            end
        end
        read_all();
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        rd_vld       = 1'b0;
        bus.hc       = 10'd0;
        bus.vc       = 10'd0;
        bus.rd_addr  = 4'd0;
        bus.wr_req   = 1'b0;
        bus.wr_addr  = 4'd0;
        bus.wr_data  = 4'd0;
        bus.clr_req  = 1'b0;
        for (int a = 0; a < 16; a++) model[a] = 4'd0;

        test_reset();
        test_deferred_write();
        test_boundary();
        test_full_clear();
        test_interrupted_clear();
        test_priority();
        test_read_during_write();
        test_reset_mid_clear();

        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
